// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the parametrised UART core.
//   uart_state_e : FSM states used by both the TX and RX machines
//   PARITY_*     : encodings of the PARITY parameter
//   parityBit    : parity bit for a word, given its XOR reduction and mode
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Even parity makes the total count of ones even, so the bit equals the
  // XOR of the data; odd parity is its complement.
  function automatic logic parityBit(input logic dataXor, input int mode);
    case (mode)
      PARITY_EVEN: parityBit = dataXor;
      PARITY_ODD:  parityBit = ~dataXor;
      default:     parityBit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running oversample tick generator shared by TX and RX.
//   clock   in  system clock
//   reset   in  synchronous active-low reset
//   os_tick out one-cycle pulse every DIV clocks,
//               DIV = max(1, CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE))
module uart_baud_gen #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clock,
  input  logic reset,
  output logic os_tick
);

  localparam int RAW_DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (RAW_DIV < 1) ? 1 : RAW_DIV;
  // A divide-by-one still needs a 1-bit counter to exist; it just never moves.
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] divCnt_q;
  logic          tick_q;

  // Divider counter runs 0..DIV-1 and emits a registered tick on the
  // terminal count, so the tick is glitch-free for both FSMs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      divCnt_q <= '0;
      tick_q   <= 1'b0;
    end else if (divCnt_q == CNT_LAST) begin
      divCnt_q <= '0;
      tick_q   <= 1'b1;
    end else begin
      divCnt_q <= divCnt_q + 1'b1;
      tick_q   <= 1'b0;
    end
  end

  assign os_tick = tick_q;

endmodule

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART core.
//   clock, reset          system clock, synchronous active-low reset
//   loopback              1: RX listens to our own tx_out instead of rx_in
//   tx_valid/tx_data      word offered for transmission (LSB first)
//   tx_ready              high only while the TX machine is idle
//   tx_out, tx_busy       serial line (idle high), frame in progress
//   rx_in                 asynchronous serial input
//   rx_valid              one-cycle pulse qualifying rx_data and error flags
//   rx_data               received word, held until the next rx_valid
//   rx_parity_err         parity mismatch on the last frame
//   rx_frame_err          first stop bit of the last frame sampled low
//   rx_busy               RX frame in progress
module uart_param
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 loopback,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  input  logic                 rx_in,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int OW = $clog2(OVERSAMPLE);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PARITY_NONE);

  logic os_tick;

  uart_baud_gen #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud (
    .clock  (clock),
    .reset  (reset),
    .os_tick(os_tick)
  );

  // ---------------------------------------------------------------- TX side
  uart_state_e          txState_q;
  logic                 txOut_q;
  logic [DATA_BITS-1:0] txShift_q;
  logic                 txPar_q;
  logic [OW-1:0]        txOs_q;
  logic [BW-1:0]        txBit_q;
  logic                 txBitEnd;

  assign txBitEnd = os_tick && (txOs_q == OS_LAST);

  // TX machine. The word and its parity are captured at accept; the shift
  // register then feeds the line one bit per OVERSAMPLE ticks. txBit_q is
  // reused to count stop bits once the data phase is over.
  always_ff @(posedge clock) begin
    if (!reset) begin
      txState_q <= ST_IDLE;
      txOut_q   <= 1'b1;
      txShift_q <= '0;
      txPar_q   <= 1'b0;
      txOs_q    <= '0;
      txBit_q   <= '0;
    end else begin
      if (txState_q != ST_IDLE && os_tick)
        txOs_q <= txBitEnd ? '0 : txOs_q + 1'b1;
      case (txState_q)
        ST_IDLE: begin
          txOut_q <= 1'b1;
          if (tx_valid) begin
            txState_q <= ST_START;
            txOut_q   <= 1'b0;
            txShift_q <= tx_data;
            txPar_q   <= parityBit(^tx_data, PARITY);
            txOs_q    <= '0;
            txBit_q   <= '0;
          end
        end
        ST_START: if (txBitEnd) begin
          txState_q <= ST_DATA;
          txOut_q   <= txShift_q[0];
        end
        ST_DATA: if (txBitEnd) begin
          if (txBit_q == DATA_LAST) begin
            txBit_q <= '0;
            if (HAS_PAR) begin
              txState_q <= ST_PARITY;
              txOut_q   <= txPar_q;
            end else begin
              txState_q <= ST_STOP;
              txOut_q   <= 1'b1;
            end
          end else begin
            txBit_q   <= txBit_q + 1'b1;
            txShift_q <= txShift_q >> 1;
            txOut_q   <= txShift_q[1];
          end
        end
        ST_PARITY: if (txBitEnd) begin
          txState_q <= ST_STOP;
          txOut_q   <= 1'b1;
        end
        ST_STOP: if (txBitEnd) begin
          if (txBit_q == STOP_LAST) txState_q <= ST_IDLE;
          else                      txBit_q   <= txBit_q + 1'b1;
        end
        default: begin
          txState_q <= ST_IDLE;
          txOut_q   <= 1'b1;
        end
      endcase
    end
  end

  assign tx_out   = txOut_q;
  assign tx_ready = (txState_q == ST_IDLE);
  assign tx_busy  = (txState_q != ST_IDLE);

  // ---------------------------------------------------------------- RX side
  logic rxMeta_q, rxSync_q, rxPrev_q;
  logic rxFall;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  // All three reset high so a reset never looks like a start bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= loopback ? txOut_q : rx_in;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  assign rxFall = rxPrev_q & ~rxSync_q;

  uart_state_e          rxState_q;
  logic [DATA_BITS-1:0] rxShift_q;
  logic [DATA_BITS-1:0] rxData_q;
  logic [OW-1:0]        rxOs_q;
  logic [BW-1:0]        rxBit_q;
  logic                 rxParPend_q;
  logic                 rxValid_q, rxParErr_q, rxFrameErr_q;
  logic                 rxSample;

  // START waits half a bit to land in the middle of the start bit; every
  // later sample is a whole bit further on, i.e. at bit centres.
  assign rxSample = os_tick &&
                    (rxOs_q == ((rxState_q == ST_START) ? OS_HALF : OS_LAST));

  // RX machine. The frame result is published at the centre of the first
  // stop bit and the machine returns to IDLE straight away, leaving half a
  // bit of margin to catch the next start edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rxState_q    <= ST_IDLE;
      rxShift_q    <= '0;
      rxData_q     <= '0;
      rxOs_q       <= '0;
      rxBit_q      <= '0;
      rxParPend_q  <= 1'b0;
      rxValid_q    <= 1'b0;
      rxParErr_q   <= 1'b0;
      rxFrameErr_q <= 1'b0;
    end else begin
      rxValid_q <= 1'b0;
      if (rxState_q != ST_IDLE && os_tick)
        rxOs_q <= rxSample ? '0 : rxOs_q + 1'b1;
      case (rxState_q)
        ST_IDLE: if (rxFall) begin
          rxState_q <= ST_START;
          rxOs_q    <= '0;
          rxBit_q   <= '0;
        end
        ST_START: if (rxSample) begin
          rxParPend_q <= 1'b0;
          rxState_q   <= rxSync_q ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (rxSample) begin
          rxShift_q <= {rxSync_q, rxShift_q[DATA_BITS-1:1]};
          if (rxBit_q == DATA_LAST) begin
            rxBit_q   <= '0;
            rxState_q <= HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            rxBit_q <= rxBit_q + 1'b1;
          end
        end
        ST_PARITY: if (rxSample) begin
          rxParPend_q <= (rxSync_q != parityBit(^rxShift_q, PARITY));
          rxState_q   <= ST_STOP;
        end
        ST_STOP: if (rxSample) begin
          rxValid_q    <= 1'b1;
          rxData_q     <= rxShift_q;
          rxParErr_q   <= rxParPend_q;
          rxFrameErr_q <= ~rxSync_q;
          rxState_q    <= ST_IDLE;
        end
        default: rxState_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_valid      = rxValid_q;
  assign rx_data       = rxData_q;
  assign rx_parity_err = rxParErr_q;
  assign rx_frame_err  = rxFrameErr_q;
  assign rx_busy       = (rxState_q != ST_IDLE);

endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: directed bench for uart_param with 1 bit = 16 clocks.
// Three instances share the clock and reset: A is 8N1, B is 8E1, C is 7N2.
// Expected receive results go into expQ when a frame is launched; a monitor
// pushes every rx_valid into obsQ, and the two are popped and compared.
module tb_uart_param;

  localparam int CF = 1600;
  localparam int BR = 100;
  localparam int OS = 16;

  logic clock = 1'b0;
  logic resetN;

  // Free-running 10-unit clock
  always #5 clock = ~clock;

  logic       loopA, txValidA, txReadyA, txOutA, txBusyA, rxInA;
  logic       rxValidA, rxPerrA, rxFerrA, rxBusyA;
  logic [7:0] txDataA, rxDataA;
  logic       loopB, txValidB, txReadyB, txOutB, txBusyB, rxInB;
  logic       rxValidB, rxPerrB, rxFerrB, rxBusyB;
  logic [7:0] txDataB, rxDataB;
  logic       loopC, txValidC, txReadyC, txOutC, txBusyC, rxInC;
  logic       rxValidC, rxPerrC, rxFerrC, rxBusyC;
  logic [6:0] txDataC, rxDataC;

  uart_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(1), .OVERSAMPLE(OS)) dutA (
    .clock(clock), .reset(resetN), .loopback(loopA),
    .tx_valid(txValidA), .tx_data(txDataA), .tx_ready(txReadyA),
    .tx_out(txOutA), .tx_busy(txBusyA), .rx_in(rxInA),
    .rx_valid(rxValidA), .rx_data(rxDataA), .rx_parity_err(rxPerrA),
    .rx_frame_err(rxFerrA), .rx_busy(rxBusyA));

  uart_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2),
               .STOP_BITS(1), .OVERSAMPLE(OS)) dutB (
    .clock(clock), .reset(resetN), .loopback(loopB),
    .tx_valid(txValidB), .tx_data(txDataB), .tx_ready(txReadyB),
    .tx_out(txOutB), .tx_busy(txBusyB), .rx_in(rxInB),
    .rx_valid(rxValidB), .rx_data(rxDataB), .rx_parity_err(rxPerrB),
    .rx_frame_err(rxFerrB), .rx_busy(rxBusyB));

  uart_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(0),
               .STOP_BITS(2), .OVERSAMPLE(OS)) dutC (
    .clock(clock), .reset(resetN), .loopback(loopC),
    .tx_valid(txValidC), .tx_data(txDataC), .tx_ready(txReadyC),
    .tx_out(txOutC), .tx_busy(txBusyC), .rx_in(rxInC),
    .rx_valid(rxValidC), .rx_data(rxDataC), .rx_parity_err(rxPerrC),
    .rx_frame_err(rxFerrC), .rx_busy(rxBusyC));

  int total = 0;
  int bad   = 0;
  logic [31:0] expQ[$];
  logic [31:0] obsQ[$];
  int runC = 0;
  int lastRunC = 0;

  // Packs which-instance, data and flags into one scoreboard word
  function automatic logic [31:0] packRx(input int which, input logic [8:0] d,
                                         input logic p, input logic f);
    logic [31:0] r;
    r        = '0;
    r[8:0]   = d;
    r[12]    = f;
    r[16]    = p;
    r[21:20] = 2'(which);
    return r;
  endfunction

  // Receive monitor: every rx_valid pulse from any instance is recorded
  always @(negedge clock) begin
    if (rxValidA) obsQ.push_back(packRx(0, {1'b0, rxDataA}, rxPerrA, rxFerrA));
    if (rxValidB) obsQ.push_back(packRx(1, {1'b0, rxDataB}, rxPerrB, rxFerrB));
    if (rxValidC) obsQ.push_back(packRx(2, {2'b0, rxDataC}, rxPerrC, rxFerrC));
  end

  // Length of the most recent high stretch on C's line, closed by a low
  always @(negedge clock) begin
    if (txOutC === 1'b1) runC <= runC + 1;
    else begin
      if (runC > 0) lastRunC <= runC;
      runC <= 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic setLine(input int which, input logic v);
    case (which)
      0: rxInA = v;
      1: rxInB = v;
      default: rxInC = v;
    endcase
  endtask

  function automatic logic getTx(input int which);
    case (which)
      0: return txOutA;
      1: return txOutB;
      default: return txOutC;
    endcase
  endfunction

  // Drives one serial frame onto an instance's rx_in, then one idle bit
  task automatic applyStimulus(input int which, input logic [8:0] data,
                               input int nBits, input bit hasPar,
                               input logic parBit, input logic stopVal);
    setLine(which, 1'b0);
    waitCycles(OS);
    for (int i = 0; i < nBits; i++) begin
      setLine(which, data[i]);
      waitCycles(OS);
    end
    if (hasPar) begin
      setLine(which, parBit);
      waitCycles(OS);
    end
    setLine(which, stopVal);
    waitCycles(OS);
    setLine(which, 1'b1);
    waitCycles(OS);
  endtask

  // Offers one word for a single cycle; the instance is idle beforehand
  task automatic sendTx(input int which, input logic [8:0] d);
    case (which)
      0: begin txDataA = d[7:0]; txValidA = 1'b1; end
      1: begin txDataB = d[7:0]; txValidB = 1'b1; end
      default: begin txDataC = d[6:0]; txValidC = 1'b1; end
    endcase
    waitCycles(1);
    txValidA = 1'b0;
    txValidB = 1'b0;
    txValidC = 1'b0;
  endtask

  // Samples tx_out at each bit centre, starting right after the accept edge
  task automatic checkTxFrame(input int which, input string tag,
                              input logic [15:0] bits, input int n);
    waitCycles(OS / 2 - 1);
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s_bit%0d", tag, k), 32'(getTx(which)),
                  32'(bits[k]));
      if (k < n - 1) waitCycles(OS);
    end
  endtask

  task automatic waitObs(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && obsQ.size() < n; i++) waitCycles(1);
    checkOutput({tag, "_count"}, 32'(obsQ.size()), 32'(n));
  endtask

  task automatic popCompare(input string tag);
    logic [31:0] e, o;
    if (obsQ.size() == 0) begin
      checkOutput({tag, "_present"}, 32'(obsQ.size()), 32'd1);
      if (expQ.size() > 0) void'(expQ.pop_front());
    end else begin
      o = obsQ.pop_front();
      e = (expQ.size() > 0) ? expQ.pop_front() : 32'hFFFF_FFFF;
      checkOutput(tag, o, e);
    end
  endtask

  initial begin
    resetN = 1'b0;
    loopA = 1'b0; loopB = 1'b0; loopC = 1'b0;
    txValidA = 1'b0; txValidB = 1'b0; txValidC = 1'b0;
    txDataA = '0; txDataB = '0; txDataC = '0;
    rxInA = 1'b1; rxInB = 1'b1; rxInC = 1'b1;
    waitCycles(3);

    // Reset state
    checkOutput("rst_tx_out", 32'(txOutA), 32'd1);
    checkOutput("rst_tx_ready", 32'(txReadyA), 32'd1);
    checkOutput("rst_tx_busy", 32'(txBusyA), 32'd0);
    checkOutput("rst_rx_valid", 32'(rxValidA), 32'd0);
    checkOutput("rst_rx_data", 32'(rxDataA), 32'd0);
    checkOutput("rst_errs", {30'd0, rxPerrA, rxFerrA}, 32'd0);
    checkOutput("rst_rx_busy", 32'(rxBusyA), 32'd0);
    checkOutput("rst_tx_out_c", 32'(txOutC), 32'd1);
    resetN = 1'b1;
    waitCycles(4);

    // 1: 8N1 loopback of 0xA5
    loopA = 1'b1;
    expQ.push_back(packRx(0, 9'h0A5, 1'b0, 1'b0));
    sendTx(0, 9'h0A5);
    checkTxFrame(0, "t1_tx", {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    waitObs("t1_rx", 1, 200);
    popCompare("t1_rx");
    waitCycles(20);
    loopA = 1'b0;

    // 2: even parity on TX of 0x07, then a bad-parity frame into RX
    sendTx(1, 9'h007);
    checkTxFrame(1, "t2_tx", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    waitCycles(OS);
    expQ.push_back(packRx(1, 9'h007, 1'b1, 1'b0));
    applyStimulus(1, 9'h007, 8, 1'b1, 1'b0, 1'b1);
    waitObs("t2_rx", 1, 100);
    popCompare("t2_rx");

    // 3: frame 0x3C with its stop bit low
    expQ.push_back(packRx(0, 9'h03C, 1'b0, 1'b1));
    applyStimulus(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0);
    waitObs("t3_rx", 1, 100);
    popCompare("t3_rx");
    waitCycles(10);
    checkOutput("t3_hold", 32'(rxDataA), 32'h3C);

    // 4: 4-clock glitch; START is entered, then abandoned at its mid sample
    setLine(0, 1'b0);
    waitCycles(4);
    setLine(0, 1'b1);
    checkOutput("t4_busy_hi", 32'(rxBusyA), 32'd1);
    waitCycles(7);
    checkOutput("t4_busy_lo", 32'(rxBusyA), 32'd0);
    waitCycles(40);
    checkOutput("t4_no_valid", 32'(obsQ.size()), 32'd0);

    // 5: reset during data bit 3 of a loopback frame, then a clean frame
    loopA = 1'b1;
    sendTx(0, 9'h033);
    waitCycles(69);
    checkOutput("t5_busy_pre", {30'd0, txBusyA, rxBusyA}, 32'd3);
    resetN = 1'b0;
    waitCycles(1);
    checkOutput("t5_tx_out", 32'(txOutA), 32'd1);
    checkOutput("t5_tx_ready", 32'(txReadyA), 32'd1);
    checkOutput("t5_rx_busy", 32'(rxBusyA), 32'd0);
    resetN = 1'b1;
    waitCycles(200);
    checkOutput("t5_no_valid", 32'(obsQ.size()), 32'd0);
    expQ.push_back(packRx(0, 9'h05A, 1'b0, 1'b0));
    sendTx(0, 9'h05A);
    waitObs("t5_rx", 1, 300);
    popCompare("t5_rx");
    loopA = 1'b0;

    // 6: 7N2 back-to-back with tx_valid held across both words
    loopC = 1'b1;
    expQ.push_back(packRx(2, 9'h011, 1'b0, 1'b0));
    expQ.push_back(packRx(2, 9'h07F, 1'b0, 1'b0));
    txDataC = 7'h11;
    txValidC = 1'b1;
    waitCycles(1);
    txDataC = 7'h7F;
    checkOutput("t6_ready_low", 32'(txReadyC), 32'd0);
    for (int i = 0; i < 400 && txReadyC !== 1'b1; i++) waitCycles(1);
    checkOutput("t6_ready_back", 32'(txReadyC), 32'd1);
    waitCycles(1);
    txValidC = 1'b0;
    checkOutput("t6_second_accept", 32'(txReadyC), 32'd0);
    waitObs("t6_rx", 2, 600);
    // two stop bits plus the single IDLE cycle in which the word is taken
    checkOutput("t6_stop_gap", 32'(lastRunC), 32'd33);
    popCompare("t6_rx0");
    popCompare("t6_rx1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
